// File: rtl/spi_slave.sv
// SPI mode-0 target endpoint: synchronized pins, MSB-first rx/tx shifters and a
// one-entry TX holding buffer with a ready/load handshake.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  mosi,
  input  logic                  cs,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);
  // state | meaning
  // IDLE  | cs deasserted, miso held low, spi_clk edges ignored
  // SHIFT | cs asserted, shifting words on spi_clk edges
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]  buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   miso_q, miso_d;
  logic                   underrun_q, underrun_d;
  logic                   load_pend_q, load_pend_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, load_pt;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    underrun_d  = 1'b0;
    load_pend_d = load_pend_q;
    load_pt     = 1'b0;

    if (tx_load && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d     = SHIFT;
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
          load_pt     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          miso_d      = 1'b0;
          load_pend_d = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            load_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (sclk_fall) begin
          if (load_pend_q) begin
            load_pt     = 1'b1;
            load_pend_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_d     = tx_shift_q[DATA_WIDTH-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load point always samples the buffer as it was before this cycle's tx_load.
    if (load_pt) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
        miso_d     = buf_q[DATA_WIDTH-1];
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
        miso_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      underrun_q  <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      underrun_q  <= underrun_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = ~cs_s;
  assign tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master with 16-clk spi_clk period and
// hand-computed expected words.
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_clk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs = 1'b1;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .mosi(mosi), .cs(cs),
    .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  // Count every high cycle so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rx_cnt  <= rx_cnt + 1;
        rx_last <= rx_data;
      end
      if (tx_underrun) ur_cnt <= ur_cnt + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic begin_xfer();
    cs = 1'b0;
    tick(8);
  endtask

  // Leaves spi_clk high after the last bit; the next call or end_xfer drops it.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b0;
      mosi = mo[7-i];
      tick(8);
      spi_clk = 1'b1;
      mi = {mi[6:0], miso};
      tick(8);
    end
  endtask

  task automatic end_xfer();
    spi_clk = 1'b0;
    tick(8);
    cs = 1'b1;
    tick(8);
  endtask

  initial begin
    logic [7:0] mi;
    int rx_base, ur_base;

    // Reset with a live bus
    cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spi_clk = ~spi_clk;
      tick(1);
    end
    check("rst_miso", int'(miso), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_rx_data", int'(rx_data), 'h00);
    check("rst_underrun", int'(tx_underrun), 0);
    cs = 1'b1;
    spi_clk = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(8);
    check("idle_busy", int'(busy), 0);

    // Single word
    rx_base = rx_cnt; ur_base = ur_cnt;
    load_tx(8'hA5);
    check("single_ready_low", int'(tx_ready), 0);
    begin_xfer();
    check("single_busy", int'(busy), 1);
    check("single_ready_back", int'(tx_ready), 1);
    xfer(8'h3C, 8, mi);
    tick(1);
    check("single_miso", int'(mi), 'hA5);
    check("single_rx_cnt", rx_cnt - rx_base, 1);
    check("single_rx_word", int'(rx_last), 'h3C);
    check("single_rx_data", int'(rx_data), 'h3C);
    check("single_no_ur", ur_cnt - ur_base, 0);
    end_xfer();
    check("single_busy_off", int'(busy), 0);
    check("single_miso_idle", int'(miso), 0);

    // Back-to-back; the second load while full must be ignored
    rx_base = rx_cnt; ur_base = ur_cnt;
    load_tx(8'h11);
    load_tx(8'h99);
    begin_xfer();
    load_tx(8'h22);
    check("b2b_ready_full", int'(tx_ready), 0);
    xfer(8'hF0, 8, mi);
    check("b2b_miso0", int'(mi), 'h11);
    check("b2b_rx0", int'(rx_last), 'hF0);
    xfer(8'h0F, 8, mi);
    tick(1);
    check("b2b_miso1", int'(mi), 'h22);
    check("b2b_rx1", int'(rx_last), 'h0F);
    check("b2b_rx_cnt", rx_cnt - rx_base, 2);
    check("b2b_no_ur", ur_cnt - ur_base, 0);
    end_xfer();

    // Underrun
    rx_base = rx_cnt; ur_base = ur_cnt;
    begin_xfer();
    check("ur_pulse", ur_cnt - ur_base, 1);
    xfer(8'h81, 8, mi);
    tick(1);
    check("ur_miso", int'(mi), 'h00);
    check("ur_rx_data", int'(rx_data), 'h81);
    check("ur_single", ur_cnt - ur_base, 1);
    end_xfer();

    // Abort after 4 bits
    rx_base = rx_cnt;
    begin_xfer();
    xfer(8'hC3, 4, mi);
    end_xfer();
    check("abort_no_valid", rx_cnt - rx_base, 0);
    check("abort_rx_kept", int'(rx_data), 'h81);
    begin_xfer();
    xfer(8'h55, 8, mi);
    tick(1);
    check("abort_next_rx", int'(rx_data), 'h55);
    check("abort_next_cnt", rx_cnt - rx_base, 1);
    end_xfer();

    // Reset mid-transfer with a word waiting in the buffer
    begin_xfer();
    load_tx(8'h77);
    check("rstmid_ready_low", int'(tx_ready), 0);
    rx_base = rx_cnt;
    xfer(8'hFF, 3, mi);
    reset = 1'b1;
    cs = 1'b1;
    spi_clk = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(8);
    check("rstmid_ready", int'(tx_ready), 1);
    check("rstmid_no_valid", rx_cnt - rx_base, 0);
    check("rstmid_rx_data", int'(rx_data), 'h00);
    ur_base = ur_cnt;
    begin_xfer();
    check("rstmid_ur", ur_cnt - ur_base, 1);
    xfer(8'h00, 8, mi);
    check("rstmid_miso", int'(mi), 'h00);
    end_xfer();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI target (slave) endpoint for the peripheral side of our SPI links. It receives MOSI words and returns MISO words to an external master clocked by spi_clk.
Mode 0 only (CPOL=0, CPHA=0), MSB first, cs active-low. All SPI pins are asynchronous to clk and are oversampled through synchronizers; all logic runs on clk.
A one-entry TX holding buffer with a ready/load handshake feeds the MISO shifter. Received words are presented with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 8, bits per SPI word
SYNC_STAGES, 2, synchronizer flops on spi_clk, mosi and cs (minimum 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
spi_clk  in  1  SPI clock from master, asynchronous
mosi  in  1  master-out data
cs  in  1  chip select, active-low
miso  out  1  slave-out data; 0 while deselected
tx_data  in  DATA_WIDTH  next word to transmit
tx_load  in  1  writes tx_data into holding buffer when tx_ready=1
tx_ready  out  1  holding buffer empty
rx_data  out  DATA_WIDTH  last complete received word
rx_valid  out  1  one-cycle pulse, rx_data updated
busy  out  1  synchronized cs low
tx_underrun  out  1  one-cycle pulse, shifter loaded while buffer empty

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - Outputs: miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, tx_underrun=0.
  - Synchronizers preset to idle levels: spi_clk=0, cs=1, mosi=0.
  - State=IDLE, bit counter=0, holding buffer emptied.
- Synchronization and edge detection:
  - cs, spi_clk and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchronizer stage with one extra registered copy.
  - Timing requirement: each spi_clk high/low phase ≥ SYNC_STAGES+2 clk cycles. Faster clocks are unsupported.
- States:
  - IDLE → SHIFT on synchronized cs falling edge.
  - SHIFT → IDLE on synchronized cs rising edge.
  - spi_clk edges in IDLE are ignored.
- Shifter load points:
  - Load points are (a) the cs falling edge, and (b) the first spi_clk falling edge after a word completes.
  - If the buffer is full at a load point: tx shifter ← buffer, buffer emptied, tx_ready=1 on the next cycle.
  - If the buffer is empty: tx shifter ← 0 and tx_underrun pulses for 1 cycle.
  - miso is driven with shifter MSB in the cycle after the load.
- Rising spi_clk edge (SHIFT): rx shifter ← {rx shifter[W-2:0], mosi}, bit counter increments.
- Word completion: on the rising edge that makes the counter reach DATA_WIDTH:
  - rx_data ← full word, counter ← 0.
  - rx_valid pulses exactly 1 cycle, in the cycle after that edge is detected.
- Falling spi_clk edge (SHIFT, not a load point): tx shifter shifts left by 1, miso ← new MSB.
- Back-to-back words with cs held low are supported without gaps.
- tx_load handshake:
  - Accepted only when tx_ready=1; buffer captures tx_data and tx_ready drops the next cycle.
  - tx_load with tx_ready=0 is ignored and the buffer is unchanged.
- Simultaneous tx_load and load point with the buffer empty: the load point sees empty (underrun, zeros shifted) and tx_data is captured into the buffer for the next word.
- cs rising mid-word (counter ≠ 0):
  - Partial word discarded, no rx_valid, rx_data unchanged.
  - Counter ← 0, miso ← 0.
  - The holding buffer is kept.
- busy mirrors synchronized cs inverted.
- Reset mid-transfer: immediate return to reset values. No rx_valid for the partial word; any buffered tx word is lost.

Test Plan:
- Reset: hold reset 3 cycles with cs=0 and spi_clk toggling → miso=0, rx_valid=0, tx_ready=1, busy=0, rx_data=0x00.
- Single word: tx_load 0xA5, then master sends 0x3C with spi_clk period 16 clk → miso samples 1,0,1,0,0,1,0,1 on rising edges; rx_data=0x3C; single rx_valid pulse; tx_ready=1 after the cs fall; no underrun.
- Back-to-back: load 0x11, cs low, load 0x22 during word 1; master sends 0xF0,0x0F → miso carries 0x11 then 0x22; two rx_valid pulses with 0xF0, 0x0F; no underrun.
- Underrun: no tx_load, master sends 0x81 → tx_underrun pulses once at cs fall; miso constant 0; rx_data=0x81.
- Abort: cs rises after 4 bits → no rx_valid, rx_data keeps its prior value; next full transfer of 0x55 → rx_data=0x55.
- Reset mid-transfer: tx_load 0x77, assert reset after 3 bits → tx_ready=1, no rx_valid; next cs fall gives tx_underrun and miso=0.
